// File: rtl/player_key_decoder.sv
// PS/2 scan-code decoder: turns make/break byte sequences into level-held game keys.
// Optional watchdog (define PLAYER_KEY_WATCHDOG_EN) releases all keys after TIMEOUT_CYCLES of silence.
module player_key_decoder #(
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter logic [7:0] JUMP_CODE      = 8'h75,
  parameter logic [7:0] RESET_CODE     = 8'h2D,
  parameter int         TIMEOUT_CYCLES = 65_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       game_reset
);

  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("player_key_decoder: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t state, state_next;
  logic   left_next, right_next, jump_next, game_reset_next;
  logic   expire;

`ifdef PLAYER_KEY_WATCHDOG_EN
  localparam int            CW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] WD_PRE = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] wd_count;

  // Release fires only on the step into saturation; a strobe in that cycle takes priority.
  assign expire = !rx_valid && (wd_count == WD_PRE);

  always_ff @(posedge clk) begin
    if (rst)
      wd_count <= '0;
    else if (rx_valid)
      wd_count <= '0;
    else if (wd_count != WD_MAX)
      wd_count <= wd_count + 1'b1;
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    left_next       = left;
    right_next      = right;
    jump_next       = jump;
    game_reset_next = game_reset;

    if (rx_valid) begin
      if (rx_data == EXT_PREFIX) begin
        state_next = S_EXT;
      end else if (rx_data == BRK_PREFIX) begin
        state_next = (state == S_EXT || state == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
      end else begin
        // Any non-prefix byte closes the sequence; unknown codes fall through untouched.
        state_next = S_IDLE;
        case (state)
          S_IDLE:    if (rx_data == RESET_CODE) game_reset_next = 1'b1;
          S_BRK:     if (rx_data == RESET_CODE) game_reset_next = 1'b0;
          S_EXT: begin
            if (rx_data == LEFT_CODE)  left_next  = 1'b1;
            if (rx_data == RIGHT_CODE) right_next = 1'b1;
            if (rx_data == JUMP_CODE)  jump_next  = 1'b1;
          end
          S_EXT_BRK: begin
            if (rx_data == LEFT_CODE)  left_next  = 1'b0;
            if (rx_data == RIGHT_CODE) right_next = 1'b0;
            if (rx_data == JUMP_CODE)  jump_next  = 1'b0;
          end
          default: state_next = S_IDLE;
        endcase
      end
    end else if (expire) begin
      state_next      = S_IDLE;
      left_next       = 1'b0;
      right_next      = 1'b0;
      jump_next       = 1'b0;
      game_reset_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      left       <= 1'b0;
      right      <= 1'b0;
      jump       <= 1'b0;
      game_reset <= 1'b0;
    end else begin
      state      <= state_next;
      left       <= left_next;
      right      <= right_next;
      jump       <= jump_next;
      game_reset <= game_reset_next;
    end
  end

endmodule

// File: tb/tb_player_key_decoder.sv
// Self-checking bench for player_key_decoder: directed vector table, watchdog/hold sequences,
// and random byte streams checked against a prefix-queue reference model.
module tb_player_key_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       left, right, jump, game_reset;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  player_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .left       (left),
    .right      (right),
    .jump       (jump),
    .game_reset (game_reset)
  );

  // Expected outputs are packed as {left, right, jump, game_reset}.
  typedef struct {
    logic       r;
    logic       v;
    logic [7:0] d;
    logic [3:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] model_keys;
  logic [7:0] pending[$];

  task automatic add_vec(input logic r, input logic v, input logic [7:0] d, input logic [3:0] exp);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.exp = exp;
    vecs.push_back(t);
  endtask

  // Drives one cycle of inputs; a strobe is followed by an idle cycle to respect strobe spacing.
  task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] d);
    rst = r; rx_valid = v; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (v) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_output(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {left, right, jump, game_reset};
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got lrjg=%b want lrjg=%b", name, got, exp);
    end
  endtask

  task automatic model_reset();
    model_keys = 4'b0000;
    pending.delete();
  endtask

  // Reference: a key is extended if any E0 preceded it, and a break if an F0 follows the last E0.
  task automatic model_byte(input logic [7:0] b);
    bit ext;
    bit brk;
    if (b == 8'hE0 || b == 8'hF0) begin
      pending.push_back(b);
    end else begin
      ext = 0;
      brk = 0;
      foreach (pending[i]) begin
        if (pending[i] == 8'hE0) begin
          ext = 1;
          brk = 0;
        end else begin
          brk = 1;
        end
      end
      if (ext) begin
        if (b == 8'h6B) model_keys[3] = !brk;
        if (b == 8'h74) model_keys[2] = !brk;
        if (b == 8'h75) model_keys[1] = !brk;
      end else if (b == 8'h2D) begin
        model_keys[0] = !brk;
      end
      pending.delete();
    end
  endtask

  task automatic send_checked(input string name, input logic [7:0] b, input logic [3:0] exp);
    apply_stimulus(1'b0, 1'b1, b);
    check_output(name, exp);
  endtask

  initial begin
    logic       r;
    logic [7:0] b;
    logic       exp_j;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    $display("[TB] start");

    add_vec(1, 1, 8'h2D, 4'b0000);
    add_vec(1, 1, 8'hE0, 4'b0000);
    add_vec(1, 1, 8'h75, 4'b0000);
    add_vec(0, 1, 8'hE0, 4'b0000);
    add_vec(0, 1, 8'h6B, 4'b1000);
    add_vec(0, 1, 8'hE0, 4'b1000);
    add_vec(0, 1, 8'hF0, 4'b1000);
    add_vec(0, 1, 8'h6B, 4'b0000);
    add_vec(0, 1, 8'h6B, 4'b0000);
    add_vec(0, 1, 8'h2D, 4'b0001);
    add_vec(0, 1, 8'hE0, 4'b0001);
    add_vec(0, 1, 8'h2D, 4'b0001);
    add_vec(0, 1, 8'hF0, 4'b0001);
    add_vec(0, 1, 8'h2D, 4'b0000);
    add_vec(0, 1, 8'hE0, 4'b0000);
    add_vec(0, 1, 8'h74, 4'b0100);
    add_vec(0, 1, 8'hE0, 4'b0100);
    add_vec(0, 1, 8'h75, 4'b0110);
    add_vec(0, 1, 8'hE0, 4'b0110);
    add_vec(0, 1, 8'h74, 4'b0110);
    add_vec(0, 1, 8'hE0, 4'b0110);
    add_vec(0, 1, 8'hF0, 4'b0110);
    add_vec(0, 1, 8'h74, 4'b0010);
    add_vec(0, 1, 8'hE0, 4'b0010);
    add_vec(0, 1, 8'hF0, 4'b0010);
    add_vec(0, 1, 8'h75, 4'b0000);
    add_vec(0, 1, 8'hE0, 4'b0000);
    add_vec(0, 1, 8'hF0, 4'b0000);
    add_vec(0, 1, 8'hE0, 4'b0000);
    add_vec(0, 1, 8'h75, 4'b0010);
    add_vec(0, 1, 8'hFA, 4'b0010);
    add_vec(0, 1, 8'hAA, 4'b0010);
    add_vec(0, 1, 8'hE1, 4'b0010);
    add_vec(0, 1, 8'h14, 4'b0010);
    add_vec(0, 1, 8'h77, 4'b0010);
    add_vec(0, 1, 8'hE0, 4'b0010);
    add_vec(1, 0, 8'h00, 4'b0000);
    add_vec(0, 1, 8'h6B, 4'b0000);
    add_vec(0, 1, 8'hE0, 4'b0000);
    add_vec(1, 0, 8'h00, 4'b0000);
    add_vec(0, 1, 8'h2D, 4'b0001);
    add_vec(0, 1, 8'hF0, 4'b0001);
    add_vec(1, 0, 8'h00, 4'b0000);
    add_vec(0, 1, 8'h2D, 4'b0001);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].r, vecs[i].v, vecs[i].d);
      check_output($sformatf("vec%0d byte=%h", i, vecs[i].d), vecs[i].exp);
    end

    // Held jump with no further traffic: the watchdog build releases exactly 100 cycles after the strobe.
    apply_stimulus(1'b1, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    apply_stimulus(1'b0, 1'b1, 8'hE0);
    rx_valid = 1'b1; rx_data = 8'h75;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int k = 1; k <= 150; k++) begin
`ifdef PLAYER_KEY_WATCHDOG_EN
      exp_j = (k < 100);
`else
      exp_j = 1'b1;
`endif
      check_output($sformatf("hold k=%0d", k), {2'b00, exp_j, 1'b0});
      @(posedge clk); #1;
    end

    // Typematic repeats every 50 cycles keep jump asserted on every cycle.
    send_checked("repeat start", 8'hE0, {2'b00, exp_j, 1'b0});
    send_checked("repeat make", 8'h75, 4'b0010);
    for (int rep = 0; rep < 4; rep++) begin
      for (int k = 0; k < 46; k++) begin
        check_output($sformatf("repeat%0d idle%0d", rep, k), 4'b0010);
        @(posedge clk); #1;
      end
      send_checked($sformatf("repeat%0d E0", rep), 8'hE0, 4'b0010);
      send_checked($sformatf("repeat%0d 75", rep), 8'h75, 4'b0010);
    end

    // Random byte streams against the reference model.
    apply_stimulus(1'b1, 1'b0, 8'h00);
    model_reset();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2: b = 8'hE0;
        3, 4:    b = 8'hF0;
        5:       b = 8'h6B;
        6:       b = 8'h74;
        7:       b = 8'h75;
        8:       b = 8'h2D;
        default: b = 8'($urandom);
      endcase
      apply_stimulus(r, 1'b1, b);
      if (r) model_reset();
      else   model_byte(b);
      check_output($sformatf("rand%0d rst=%0b byte=%h", i, r, b), model_keys);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
